// File: rtl/cpu_fetch.sv
// cpu_fetch: fetch stage ahead of cpu_decode; owns the fetch PC, predecodes BR, predicts with a 2-bit BHT (FETCH_BPRED_EN).
// Latency: issue strobe (input_ready) one cycle after the accepting I-cache response, or after a stall is released.
// Backpressure: stall_input at response parks the word in HOLD with no I-cache request; flush redirects and drops it.
module cpu_fetch #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          BHT_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic [15:0] flush_pc,
   input  logic        stall_input,
   output logic        imem_read,
   output logic [15:0] imem_address,
   input  logic [15:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        bp_update,
   input  logic [15:0] bp_update_pc,
   input  logic        bp_taken,
   output logic [15:0] pc,
   output logic [15:0] instruction,
   output logic        branch_prediction,
   output logic        input_ready
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_fetch_pc, r_redirect_pc;
   logic [15:0] r_pc, r_instr;
   logic        r_bpred, r_ready_q;

   logic [15:0] w_fetch_pc_nxt, w_redirect_pc_nxt;
   logic        w_latch, w_ready_nxt;

   logic        w_is_br, w_br_always, w_br_never, w_bht_taken, w_fetch_taken;
   logic [15:0] w_fetch_next, w_hold_next;

   // PC-relative BR target: pc + 2 + sext(offset9) * 2, wrapping at 16 bits
   function automatic logic [15:0] f_target(input logic [15:0] a_pc, input logic [15:0] a_ir);
      return a_pc + 16'd2 + {{6{a_ir[8]}}, a_ir[8:0], 1'b0};
   endfunction

   // Predecode of the word arriving from the I-cache
   assign w_is_br       = (imem_rdata[15:12] == 4'b0000);
   assign w_br_always   = w_is_br && (imem_rdata[11:9] == 3'b111);
   assign w_br_never    = w_is_br && (imem_rdata[11:9] == 3'b000);
   assign w_fetch_taken = w_br_always | (w_is_br & ~w_br_never & w_bht_taken);
   assign w_fetch_next  = w_fetch_taken ? f_target(r_fetch_pc, imem_rdata) : r_fetch_pc + 16'd2;

   // A held word reuses the prediction it was latched with, so pc/branch_prediction stay consistent
   assign w_hold_next   = r_bpred ? f_target(r_pc, r_instr) : r_pc + 16'd2;

`ifdef FETCH_BPRED_EN
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       r_bht [BHT_ENTRIES];
   logic [IDX_W-1:0] w_lookup_idx, w_update_idx;
   logic             w_unused_bits;

   assign w_lookup_idx  = r_fetch_pc[IDX_W:1];
   assign w_update_idx  = bp_update_pc[IDX_W:1];
   // Registered table: a same-cycle update is not visible to this lookup
   assign w_bht_taken   = r_bht[w_lookup_idx][1];
   assign w_unused_bits = ^bp_update_pc;

   // Saturating 2-bit counters trained at branch resolution; reset to weakly not-taken
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            r_bht[i] <= 2'b01;
         end
      end else if (bp_update) begin
         if (bp_taken && (r_bht[w_update_idx] != 2'b11)) begin
            r_bht[w_update_idx] <= r_bht[w_update_idx] + 2'd1;
         end else if (!bp_taken && (r_bht[w_update_idx] != 2'b00)) begin
            r_bht[w_update_idx] <= r_bht[w_update_idx] - 2'd1;
         end
      end
   end
`else
   logic w_unused_bits;

   // No history: conditional BR falls through, BRnzp is still taken by predecode
   assign w_bht_taken   = 1'b0;
   assign w_unused_bits = ^{bp_update, bp_update_pc, bp_taken, (BHT_ENTRIES != 0)};
`endif

   // Next-state and control decode; defaults hold every register
   always_comb begin
      w_state_nxt       = r_state;
      w_fetch_pc_nxt    = r_fetch_pc;
      w_redirect_pc_nxt = r_redirect_pc;
      w_latch           = 1'b0;
      w_ready_nxt       = 1'b0;
      imem_read         = 1'b0;
      case (r_state)
         S_FETCH: begin
            imem_read = 1'b1;
            if (imem_resp) begin
               if (flush) begin
                  w_fetch_pc_nxt = flush_pc;
               end else begin
                  w_latch = 1'b1;
                  if (stall_input) begin
                     w_state_nxt = S_HOLD;
                  end else begin
                     w_ready_nxt    = 1'b1;
                     w_fetch_pc_nxt = w_fetch_next;
                  end
               end
            end else if (flush) begin
               // The cache cannot abort; wait out the request before redirecting
               w_redirect_pc_nxt = flush_pc;
               w_state_nxt       = S_DRAIN;
            end
         end
         S_HOLD: begin
            if (flush) begin
               w_fetch_pc_nxt = flush_pc;
               w_state_nxt    = S_FETCH;
            end else if (!stall_input) begin
               w_ready_nxt    = 1'b1;
               w_fetch_pc_nxt = w_hold_next;
               w_state_nxt    = S_FETCH;
            end
         end
         S_DRAIN: begin
            imem_read = 1'b1;
            if (imem_resp) begin
               // Latest flush wins, including one arriving with the discarded response
               w_fetch_pc_nxt = flush ? flush_pc : r_redirect_pc;
               w_state_nxt    = S_FETCH;
            end else if (flush) begin
               w_redirect_pc_nxt = flush_pc;
            end
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fetch and pending-redirect PCs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_fetch_pc    <= RESET_PC;
         r_redirect_pc <= RESET_PC;
      end else begin
         r_fetch_pc    <= w_fetch_pc_nxt;
         r_redirect_pc <= w_redirect_pc_nxt;
      end
   end

   // Issue registers toward decode; ready_q is a single-cycle pulse
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc      <= 16'h0000;
         r_instr   <= 16'h0000;
         r_bpred   <= 1'b0;
         r_ready_q <= 1'b0;
      end else begin
         r_ready_q <= w_ready_nxt;
         if (w_latch) begin
            r_pc    <= r_fetch_pc;
            r_instr <= imem_rdata;
            r_bpred <= w_fetch_taken;
         end
      end
   end

   assign imem_address      = r_fetch_pc;
   assign pc                = r_pc;
   assign instruction       = r_instr;
   assign branch_prediction = r_bpred;
   assign input_ready       = r_ready_q & ~flush;

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed table, hand-written corner sequences and randomized traffic for cpu_fetch.
// An I-cache model with variable latency answers requests; a transaction-level model predicts issues and request addresses.
module tb_cpu_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, flush, stall_input, imem_read, imem_resp;
   logic        bp_update, bp_taken, branch_prediction, input_ready;
   logic [15:0] flush_pc, imem_address, imem_rdata, bp_update_pc, pc, instruction;

   cpu_fetch #(.RESET_PC(16'h0000), .BHT_ENTRIES(16)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .flush_pc(flush_pc),
      .stall_input(stall_input), .imem_read(imem_read), .imem_address(imem_address),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp), .bp_update(bp_update),
      .bp_update_pc(bp_update_pc), .bp_taken(bp_taken), .pc(pc), .instruction(instruction),
      .branch_prediction(branch_prediction), .input_ready(input_ready)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] mem [0:32767];

   // stimulus controls
   bit          d_rst, d_flush, d_stall, d_bp, d_bp_taken, rand_lat, flush_on_resp;
   logic [15:0] d_flush_pc, d_bp_pc, fop_pc;
   int          lat_cfg;

   // cache model
   bit          c_busy;
   int          c_cnt;
   logic [15:0] c_addr;

   // per-cycle observations
   bit          s_start, s_live;

   // reference model
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] ir;
      logic        pred;
      logic [15:0] nxt;
   } item_t;

   logic [15:0] m_exp;
   bit          m_held, m_issue, m_dead;
   item_t       m_held_item, m_issue_item;
   int          m_bht [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired waiting for DUT", name);
   endtask

   function automatic item_t predict(input logic [15:0] a, input logic [15:0] ir);
      item_t it;
      int    off;
      bit    taken;
      taken = 1'b0;
      if (ir[15:12] == 4'b0000) begin
         if (ir[11:9] == 3'b111) begin
            taken = 1'b1;
         end else if (ir[11:9] != 3'b000) begin
`ifdef FETCH_BPRED_EN
            taken = (m_bht[(int'(a) / 2) % 16] >= 2);
`endif
         end
      end
      off = int'(ir[8:0]);
      if (off > 255) off -= 512;
      it.pc   = a;
      it.ir   = ir;
      it.pred = taken;
      it.nxt  = taken ? 16'(int'(a) + 2 + 2 * off) : 16'(int'(a) + 2);
      return it;
   endfunction

   task automatic model_reset();
      m_exp   = 16'h0000;
      m_held  = 1'b0;
      m_issue = 1'b0;
      m_dead  = 1'b0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
   endtask

   task automatic model_step(input bit start, input bit rsp);
      bit    exp_rdy;
      bit    new_issue;
      item_t it;
      int    idx;
      exp_rdy = m_issue && !flush;
      check("input_ready", input_ready, exp_rdy);
      if (exp_rdy) begin
         check("issue_pc", pc, m_issue_item.pc);
         check("issue_instr", instruction, m_issue_item.ir);
         check("issue_pred", branch_prediction, m_issue_item.pred);
      end
      check("imem_read", imem_read, !m_held);
      if (start) begin
         check("req_addr", imem_address, m_exp);
         m_dead = 1'b0;
      end
      new_issue = 1'b0;
      if (flush) begin
         m_dead = 1'b1;
         m_held = 1'b0;
         m_exp  = flush_pc;
      end else if (rsp && !m_dead) begin
         it = predict(c_addr, imem_rdata);
         if (stall_input) begin
            m_held      = 1'b1;
            m_held_item = it;
         end else begin
            new_issue    = 1'b1;
            m_issue_item = it;
            m_exp        = it.nxt;
         end
      end else if (m_held && !stall_input) begin
         new_issue    = 1'b1;
         m_issue_item = m_held_item;
         m_held       = 1'b0;
         m_exp        = m_held_item.nxt;
      end
      m_issue = new_issue;
      if (bp_update) begin
         idx = (int'(bp_update_pc) / 2) % 16;
         if (bp_taken && m_bht[idx] < 3) m_bht[idx]++;
         else if (!bp_taken && m_bht[idx] > 0) m_bht[idx]--;
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, let them settle, then check
   task automatic cyc();
      bit start, rsp;
      @(negedge clk);
      start = 1'b0;
      rsp   = 1'b0;
      if (d_rst) begin
         c_busy = 1'b0;
      end else begin
         if (imem_read && !c_busy) begin
            start  = 1'b1;
            c_busy = 1'b1;
            c_addr = imem_address;
            c_cnt  = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
         end
         if (c_busy) begin
            if (c_cnt == 0) rsp = 1'b1;
            else c_cnt--;
         end
      end
      reset_n = !d_rst;
      if (flush_on_resp && rsp) begin
         flush         = 1'b1;
         flush_pc      = fop_pc;
         flush_on_resp = 1'b0;
      end else begin
         flush    = d_flush;
         flush_pc = d_flush_pc;
      end
      stall_input  = d_stall;
      imem_resp    = rsp;
      imem_rdata   = rsp ? mem[c_addr[15:1]] : 16'($urandom);
      bp_update    = d_bp;
      bp_update_pc = d_bp_pc;
      bp_taken     = d_bp_taken;
      #1;
      s_start = start;
      s_live  = rsp && !flush;
      if (d_rst) model_reset();
      else model_step(start, rsp);
      if (rsp) c_busy = 1'b0;
      d_flush = 1'b0;
      d_bp    = 1'b0;
   endtask

   task automatic do_reset();
      d_rst = 1'b1;
      cyc();
      cyc();
      d_rst = 1'b0;
   endtask

   task automatic wait_pulse(input string name, input int max, output int waited);
      waited = 0;
      do begin
         cyc();
         waited++;
      end while (!input_ready && waited < max);
      if (!input_ready) timeout(name);
   endtask

   task automatic wait_live(input string name, input int max);
      int n = 0;
      do begin
         cyc();
         n++;
      end while (!s_live && n < max);
      if (!s_live) timeout(name);
   endtask

   task automatic wait_start(input string name, input int max, output int pulses);
      int n = 0;
      pulses = 0;
      do begin
         cyc();
         n++;
         if (input_ready) pulses++;
      end while (!s_start && n < max);
      if (!s_start) timeout(name);
   endtask

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] ir;
      logic        pred;
      logic [15:0] nxt;
   } vec_t;

   initial begin
      vec_t        tbl [9];
      int          w, pulses;
      logic [15:0] rw, old_addr;
      bit          bpred_on;

`ifdef FETCH_BPRED_EN
      bpred_on = 1'b1;
`else
      bpred_on = 1'b0;
`endif
      // pc, instruction, expected prediction, expected next fetch address
      tbl[0] = '{16'h0000, 16'h1020, 1'b0, 16'h0002};   // ALU word
      tbl[1] = '{16'h0010, 16'h0FFE, 1'b1, 16'h000E};   // BRnzp -2
      tbl[2] = '{16'hFFFE, 16'h1020, 1'b0, 16'h0000};   // pc+2 wraps
      tbl[3] = '{16'h0100, 16'h0E05, 1'b1, 16'h010C};   // BRnzp +5
      tbl[4] = '{16'h0200, 16'h0005, 1'b0, 16'h0202};   // BR nzp=000 (NOP)
      tbl[5] = '{16'h0300, 16'h0405, 1'b0, 16'h0302};   // BRz, fresh counter
      tbl[6] = '{16'h0400, 16'hC1C0, 1'b0, 16'h0402};   // JMP
      tbl[7] = '{16'hFFF0, 16'h0E07, 1'b1, 16'h0000};   // target wraps
      tbl[8] = '{16'h0000, 16'h0F00, 1'b1, 16'hFE02};   // most negative offset

      reset_n = 1'b0; flush = 1'b0; flush_pc = 16'h0; stall_input = 1'b0;
      imem_resp = 1'b0; imem_rdata = 16'h0; bp_update = 1'b0; bp_update_pc = 16'h0; bp_taken = 1'b0;
      d_flush = 0; d_stall = 0; d_bp = 0; d_bp_taken = 0; d_flush_pc = 0; d_bp_pc = 0;
      rand_lat = 0; flush_on_resp = 0; fop_pc = 0; lat_cfg = 1; c_busy = 0; c_cnt = 0; c_addr = 0;
      model_reset();

      for (int i = 0; i < 32768; i++) begin
         rw = 16'($urandom);
         if ($urandom_range(0, 1) == 1) rw[15:12] = 4'b0000;
         mem[i] = rw;
      end

      // Reset state, then first fetch with a one-cycle-latency cache
      mem[0] = 16'h1020;
      do_reset();
      cyc();
      check("rst_imem_read", imem_read, 1'b1);
      check("rst_imem_address", imem_address, 16'h0000);
      check("rst_input_ready", input_ready, 1'b0);
      check("rst_pc", pc, 16'h0000);
      check("rst_instruction", instruction, 16'h0000);
      check("rst_bpred", branch_prediction, 1'b0);
      wait_pulse("first_pulse", 10, w);
      check("first_latency", w, 2);
      check("first_pc", pc, 16'h0000);
      check("first_instr", instruction, 16'h1020);
      check("first_next_addr", imem_address, 16'h0002);

      // Predecode / next-PC table
      for (int i = 0; i < 9; i++) begin
         mem[tbl[i].pc[15:1]] = tbl[i].ir;
         d_flush    = 1'b1;
         d_flush_pc = tbl[i].pc;
         wait_pulse($sformatf("tbl%0d_pulse", i), 20, w);
         check($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
         check($sformatf("tbl%0d_instr", i), instruction, tbl[i].ir);
         check($sformatf("tbl%0d_pred", i), branch_prediction, tbl[i].pred);
         check($sformatf("tbl%0d_next", i), imem_address, tbl[i].nxt);
      end

      // Stall at response: parked three cycles, then exactly one pulse
      lat_cfg = 2;
      mem[16'h0500 >> 1] = 16'h1234;
      d_stall = 1'b1; d_flush = 1'b1; d_flush_pc = 16'h0500;
      cyc();
      wait_live("stall_resp", 20);
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("hold_no_pulse", input_ready, 1'b0);
         check("hold_no_read", imem_read, 1'b0);
      end
      d_stall = 1'b0;
      pulses  = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (input_ready) begin
            pulses++;
            check("hold_pc", pc, 16'h0500);
            check("hold_instr", instruction, 16'h1234);
            check("hold_next", imem_address, 16'h0502);
         end
      end
      check("hold_pulse_count", pulses, 1);

      // Flush while a slow response is pending: drained, then redirected
      lat_cfg = 4;
      wait_start("drain_start", 40, pulses);
      old_addr   = imem_address;
      d_flush    = 1'b1;
      d_flush_pc = 16'h4000;
      cyc();
      check("drain_flush_pulse", input_ready, 1'b0);
      cyc();
      check("drain_read", imem_read, 1'b1);
      check("drain_old_addr", imem_address, old_addr);
      wait_start("drain_redirect", 20, pulses);
      check("drain_addr", imem_address, 16'h4000);
      check("drain_no_pulse", pulses, 0);

      // Flush in the pulse cycle squashes the pulse
      lat_cfg = 1;
      mem[16'h0600 >> 1] = 16'h1020;
      d_flush = 1'b1; d_flush_pc = 16'h0600;
      wait_live("squash_resp", 20);
      d_flush = 1'b1; d_flush_pc = 16'h0700;
      cyc();
      check("squash_pulse", input_ready, 1'b0);
      wait_start("squash_redirect", 20, pulses);
      check("squash_addr", imem_address, 16'h0700);
      check("squash_no_pulse", pulses, 0);

      // Flush with the response: word dropped, fetch restarts at flush_pc
      lat_cfg = 2;
      mem[16'h0900 >> 1] = 16'h5A5A;
      fop_pc = 16'h0900; flush_on_resp = 1'b1;
      w = 0;
      while (flush_on_resp && w < 20) begin
         cyc();
         w++;
      end
      if (flush_on_resp) timeout("flush_resp_fire");
      flush_on_resp = 1'b0;
      cyc();
      check("flush_resp_no_pulse", input_ready, 1'b0);
      wait_pulse("flush_resp_pulse", 20, w);
      check("flush_resp_pc", pc, 16'h0900);
      check("flush_resp_instr", instruction, 16'h5A5A);

      // BHT training on BRz at 0x0020
      do_reset();
      lat_cfg = 1;
      mem[16'h0020 >> 1] = 16'h0405;
      for (int k = 0; k < 2; k++) begin
         d_bp = 1'b1; d_bp_pc = 16'h0020; d_bp_taken = 1'b1;
         cyc();
      end
      d_flush = 1'b1; d_flush_pc = 16'h0020;
      wait_pulse("bht_taken_pulse", 20, w);
      check("bht_taken_pred", branch_prediction, bpred_on);
      check("bht_taken_next", imem_address, bpred_on ? 16'h002C : 16'h0022);
      for (int k = 0; k < 3; k++) begin
         d_bp = 1'b1; d_bp_pc = 16'h0020; d_bp_taken = 1'b0;
         cyc();
      end
      d_flush = 1'b1; d_flush_pc = 16'h0020;
      wait_pulse("bht_nt_pulse", 20, w);
      check("bht_nt_pred", branch_prediction, 1'b0);
      check("bht_nt_next", imem_address, 16'h0022);

      // Randomized traffic against the reference model
      rand_lat = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         d_rst      = ($urandom_range(0, 399) == 0);
         d_flush    = ($urandom_range(0, 15) == 0);
         d_flush_pc = 16'($urandom) & 16'hFFFE;
         d_stall    = ($urandom_range(0, 2) == 0);
         d_bp       = ($urandom_range(0, 3) == 0);
         d_bp_pc    = 16'($urandom_range(0, 63)) & 16'hFFFE;
         d_bp_taken = ($urandom_range(0, 1) == 1);
         cyc();
      end
      d_rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
